// File: rtl/decsel_arb_if.sv
// ============================================================================
// Module      : decsel_arb_if
// Description : Request/decoder bundle between the decoder-select arbiter and
//               its requesters plus the external 3-to-8 decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decsel_arb_if;
  logic [7:0] req_;   // active-low requests, bit i = requester i
  logic       done_;  // active-low access complete from selected device
  logic       en;     // new grants allowed
  logic [3:0] wlen;   // minimum ACTIVE length minus one
  logic       a;      // decoder select bit 0
  logic       b;      // decoder select bit 1
  logic       c;      // decoder select bit 2
  logic       g1;     // decoder enable
  logic       g2a_;   // active-low access strobe
  logic       g2b_;   // active-low window enable
  logic       busy;   // arbiter not idle
  logic       tmo;    // access aborted by timeout

  // Arbiter side
  modport master (
    input  req_, done_, en, wlen,
    output a, b, c, g1, g2a_, g2b_, busy, tmo
  );

  // Requester / decoder side
  modport slave (
    output req_, done_, en, wlen,
    input  a, b, c, g1, g2a_, g2b_, busy, tmo
  );
endinterface

`default_nettype wire

// File: rtl/decsel_arb.sv
// ============================================================================
// Module      : decsel_arb
// Description : Round-robin arbiter for 8 active-low requesters driving the
//               select/enable pins of an external 3-to-8 decoder. Each grant
//               runs SETUP -> ACTIVE -> RECOVER with a minimum ACTIVE length
//               and an ACTIVE timeout. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decsel_arb #(
  parameter int TMAX = 255
) (
  input  wire logic     clk,
  input  wire logic     rst_,
  decsel_arb_if.master  bus
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_setup   = 2'd1;
  localparam logic [1:0] c_active  = 2'd2;
  localparam logic [1:0] c_recover = 2'd3;

  // Timeout fires on the ACTIVE cycle whose counter equals TMAX-1,
  // giving exactly TMAX strobe cycles.
  localparam logic [7:0] c_tmax_m1 = 8'(TMAX - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] abc_q, abc_d;
  logic [2:0] last_q, last_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       g1_q, g1_d;
  logic       g2a_q, g2a_d;
  logic       g2b_q, g2b_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;

  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand;

  // Round-robin pick: first low request bit searching upward from last+1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    cand       = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_q + 3'(k);
      if (!pick_found && !bus.req_[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d = state_q;
    abc_d   = abc_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    tmo_d   = 1'b0;
    g1_d    = 1'b1;
    case (state_q)
      c_idle: begin
        // g1_q gates arbitration so it starts one edge after g1 rises.
        if (g1_q && bus.en && pick_found) begin
          abc_d   = pick_idx;
          state_d = c_setup;
        end
      end
      c_setup: begin
        wcnt_d  = bus.wlen;
        tcnt_d  = 8'd0;
        state_d = c_active;
      end
      c_active: begin
        wcnt_d = (wcnt_q == 4'd0) ? 4'd0 : wcnt_q - 4'd1;
        tcnt_d = tcnt_q + 8'd1;
        if (wcnt_q == 4'd0 && !bus.done_) begin
          state_d = c_recover;
        end else if (tcnt_q == c_tmax_m1) begin
          state_d = c_recover;
          tmo_d   = 1'b1;
        end
      end
      c_recover: begin
        last_d  = abc_q;
        state_d = c_idle;
      end
      default: state_d = c_idle;
    endcase
    g2a_d  = (state_d != c_active);
    g2b_d  = (state_d == c_idle);
    busy_d = (state_d != c_idle);
  end

  // State and output registers; reset forces strobes inactive immediately.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= c_idle;
      abc_q   <= 3'd0;
      last_q  <= 3'd7;
      wcnt_q  <= 4'd0;
      tcnt_q  <= 8'd0;
      g1_q    <= 1'b0;
      g2a_q   <= 1'b1;
      g2b_q   <= 1'b1;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      abc_q   <= abc_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      g1_q    <= g1_d;
      g2a_q   <= g2a_d;
      g2b_q   <= g2b_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.a    = abc_q[0];
  assign bus.b    = abc_q[1];
  assign bus.c    = abc_q[2];
  assign bus.g1   = g1_q;
  assign bus.g2a_ = g2a_q;
  assign bus.g2b_ = g2b_q;
  assign bus.busy = busy_q;
  assign bus.tmo  = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_decsel_arb.sv
// ============================================================================
// Module      : tb_decsel_arb
// Description : Self-checking bench for decsel_arb (TMAX=8). Transaction
//               table plus hand-written reset/enable/latency sequences;
//               expected grants are queued and matched by a strobe monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decsel_arb;

  localparam int TMAX = 8;

  typedef struct {
    logic [7:0] req;
    logic [3:0] wlen;
    int         mode;   // 0 done_ low, 1 done_ high, 2 done_ low on last timeout cycle
    bit         drop;   // release request once the strobe starts
    int         idx;
    int         len;
    bit         tmo;
    int         gap;    // required strobe-high cycles before this strobe, 0 = unchecked
  } vec_t;

  typedef struct {
    int idx;
    int len;
    bit tmo;
    int gap;
  } exp_t;

  logic clk;
  logic rst_;
  decsel_arb_if bus();

  decsel_arb #(.TMAX(TMAX)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[17];

  int starts = 0;
  int dones  = 0;

  function automatic void check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic [7:0] req, input logic [3:0] wlen,
                              input int mode, input bit drop, input int idx,
                              input int len, input bit tmo, input int gap);
    vec_t v;
    v.req = req; v.wlen = wlen; v.mode = mode; v.drop = drop;
    v.idx = idx; v.len = len; v.tmo = tmo; v.gap = gap;
    return v;
  endfunction

  function automatic int abc();
    return int'({bus.c, bus.b, bus.a});
  endfunction

  // Strobe monitor: measures each g2a_ low run and the surrounding window.
  int   alow = 0, wlow = 0, blow = 0, hi_cnt = 0, last_len = 0, sidx = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_) begin
      alow = 0; wlow = 0; blow = 0; hi_cnt = 0;
    end else begin
      if (!bus.g2a_) begin
        if (alow == 0) begin
          sidx = abc();
          starts++;
          if (sb.size() > 0 && sb[0].gap != 0) check("strobe_gap", hi_cnt, sb[0].gap);
        end else if (abc() != sidx) begin
          check("abc_hold_active", abc(), sidx);
        end
        alow++;
      end else begin
        if (alow != 0) begin
          check("abc_hold_recover", abc(), sidx);
          if (sb.size() == 0) begin
            check("unexpected_strobe", 1, 0);
          end else begin
            e = sb.pop_front();
            check("grant_idx", sidx, e.idx);
            check("strobe_len", alow, e.len);
            check("tmo", int'(bus.tmo), int'(e.tmo));
          end
          last_len = alow;
          alow = 0;
          hi_cnt = 0;
          dones++;
        end
        hi_cnt++;
      end
      if (!bus.g2b_) wlow++;
      else if (wlow != 0) begin
        check("window_len", wlow, last_len + 2);
        wlow = 0;
      end
      if (bus.busy) blow++;
      else if (blow != 0) begin
        check("busy_len", blow, last_len + 2);
        blow = 0;
      end
    end
  end

  task automatic wait_start(input int s0);
    int n = 0;
    while (starts == s0 && n < 300) begin @(negedge clk); #1; n++; end
    check("start_timeout", int'(starts != s0), 1);
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (dones == d0 && n < 300) begin @(negedge clk); #1; n++; end
    check("done_timeout", int'(dones != d0), 1);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t x;
    int s0, d0;
    x.idx = v.idx; x.len = v.len; x.tmo = v.tmo; x.gap = v.gap;
    s0 = starts; d0 = dones;
    bus.req_  = v.req;
    bus.wlen  = v.wlen;
    bus.en    = 1'b1;
    bus.done_ = (v.mode == 0) ? 1'b0 : 1'b1;
    sb.push_back(x);
    wait_start(s0);
    if (v.drop) bus.req_ = 8'hFF;
    if (v.mode == 2) begin
      repeat (TMAX - 1) begin @(negedge clk); #1; end
      bus.done_ = 1'b0;
    end
    wait_done(d0);
  endtask

  initial begin
    exp_t x;
    int   s0, d0;

    for (int i = 0; i < 9; i++) tbl[i] = mk(8'h00, 4'd1, 0, 1'b0, i % 8, 2, 1'b0, (i == 0) ? 0 : 3);
    tbl[9]  = mk(8'hFB, 4'd0,  0, 1'b0, 2, 1,  1'b0, 3);
    tbl[10] = mk(8'hEF, 4'd0,  1, 1'b0, 4, 8,  1'b1, 3);
    tbl[11] = mk(8'h00, 4'd0,  1, 1'b0, 5, 8,  1'b1, 3);
    tbl[12] = mk(8'h00, 4'd0,  2, 1'b0, 6, 8,  1'b0, 3);
    tbl[13] = mk(8'h7F, 4'd3,  0, 1'b0, 7, 4,  1'b0, 3);
    tbl[14] = mk(8'hFE, 4'd15, 0, 1'b0, 0, 8,  1'b1, 3);
    tbl[15] = mk(8'h00, 4'd2,  0, 1'b0, 1, 3,  1'b0, 3);
    tbl[16] = mk(8'hFD, 4'd3,  0, 1'b1, 1, 4,  1'b0, 3);

    // Reset state
    rst_ = 1'b0; bus.req_ = 8'hFF; bus.en = 1'b0; bus.done_ = 1'b1; bus.wlen = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_g1", int'(bus.g1), 0);
    check("rst_g2a", int'(bus.g2a_), 1);
    check("rst_g2b", int'(bus.g2b_), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_tmo", int'(bus.tmo), 0);
    check("rst_abc", abc(), 0);
    rst_ = 1'b1;
    @(negedge clk); #1;
    check("g1_after_release", int'(bus.g1), 1);

    for (int i = 0; i < 17; i++) run_vec(tbl[i]);

    // en low holds off grants even with every request asserted
    bus.req_ = 8'hFF; bus.en = 1'b0; bus.done_ = 1'b0; bus.wlen = 4'd0;
    repeat (3) begin @(negedge clk); #1; end
    bus.req_ = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("en0_busy", int'(bus.busy), 0);
    end
    x.idx = 2; x.len = 1; x.tmo = 1'b0; x.gap = 0;
    sb.push_back(x);
    d0 = dones;
    bus.en = 1'b1;
    @(negedge clk); #1;
    check("en1_busy_next_edge", int'(bus.busy), 1);
    check("setup_g2a_off", int'(bus.g2a_), 1);
    check("setup_g2b_on", int'(bus.g2b_), 0);
    bus.en = 1'b0;
    @(negedge clk); #1;
    check("latency_g2a_low", int'(bus.g2a_), 0);
    wait_done(d0);

    // Asynchronous reset in the middle of an ACTIVE access to index 5
    repeat (2) begin @(negedge clk); #1; end
    s0 = starts;
    bus.req_ = 8'hDF; bus.wlen = 4'd15; bus.done_ = 1'b1; bus.en = 1'b1;
    wait_start(s0);
    check("rst_mid_idx", abc(), 5);
    #3;
    rst_ = 1'b0;
    #1;
    check("async_g2a", int'(bus.g2a_), 1);
    check("async_g2b", int'(bus.g2b_), 1);
    check("async_g1", int'(bus.g1), 0);
    check("async_abc", abc(), 0);
    check("async_busy", int'(bus.busy), 0);
    bus.req_ = 8'hF5; bus.wlen = 4'd0; bus.done_ = 1'b0;
    x.idx = 1; x.len = 1; x.tmo = 1'b0; x.gap = 0;
    sb.push_back(x);
    d0 = dones;
    repeat (2) @(negedge clk);
    #1;
    rst_ = 1'b1;
    @(negedge clk); #1;
    check("rel_g1", int'(bus.g1), 1);
    check("rel_no_grant_yet", int'(bus.busy), 0);
    @(negedge clk); #1;
    check("rel_grant_busy", int'(bus.busy), 1);
    check("rel_grant_idx", abc(), 1);
    bus.en = 1'b0;
    wait_done(d0);

    bus.req_ = 8'hFF;
    repeat (5) begin @(negedge clk); #1; end
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decsel_arb.md
DECSEL_ARB -- requirements
Module: decsel_arb

Interface
REQ-001 Parameter: TMAX, 255, ACTIVE-state timeout in cycles (1..255).
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst_  input  1  asynchronous, active-low reset.
REQ-004 Port: req_  input  8  active-low access requests; bit i = requester i.
REQ-005 Port: done_  input  1  active-low access-complete from the currently selected device.
REQ-006 Port: en  input  1  high = new grants allowed; low = no new grant starts (current access completes).
REQ-007 Port: wlen  input  4  minimum ACTIVE length minus one, sampled on SETUP->ACTIVE.
REQ-008 Port: a, b, c  output  1 each  select code to an external 3-to-8 decoder; {c,b,a} = granted index.
REQ-009 Port: g1  output  1  decoder enable, high while out of reset.
REQ-010 Port: g2a_  output  1  active-low access strobe, low only in ACTIVE.
REQ-011 Port: g2b_  output  1  active-low window enable, low in SETUP, ACTIVE, RECOVER.
REQ-012 Port: busy  output  1  high in any state other than IDLE.
REQ-013 Port: tmo  output  1  one-cycle pulse when an access is aborted by timeout.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, ACTIVE, RECOVER; all outputs SHALL be registered.
REQ-015 IDLE: if en=1 and any req_ bit low, the block SHALL select the lowest-priority-distance requester searching upward from last+1 modulo 8, load {c,b,a} with it, and enter SETUP next edge.
REQ-016 IDLE with en=0 or req_=8'hFF SHALL remain IDLE with {c,b,a} holding the previous value.
REQ-017 SETUP SHALL last exactly one cycle (address setup, strobe off), then enter ACTIVE, loading wait counter = wlen and timeout counter = 0.
REQ-018 ACTIVE: wait counter SHALL decrement by one per cycle, saturating at 0; timeout counter SHALL increment by one per cycle.
REQ-019 ACTIVE SHALL exit to RECOVER on the edge where wait counter = 0 and done_ = 0.
REQ-020 ACTIVE SHALL exit to RECOVER with tmo=1 for one cycle when timeout counter reaches TMAX-1 and the REQ-019 exit is not taken; done exit has priority on the same edge.
REQ-021 Deassertion of the granted req_ bit during SETUP or ACTIVE SHALL NOT abort the access; en changes SHALL NOT affect an access in progress.
REQ-022 RECOVER SHALL last exactly one cycle with {c,b,a} held, SHALL record last = granted index, then enter IDLE; minimum gap between two strobes SHALL be 3 cycles (RECOVER, IDLE, SETUP).
REQ-023 {c,b,a} SHALL NOT change in SETUP, ACTIVE or RECOVER.
REQ-024 Latency: request seen in IDLE -> g2a_ low 2 edges later; wlen=0 with done_ already low -> g2a_ low for exactly 1 cycle.
REQ-025 Round-robin fairness: with all 8 requesting continuously, grants SHALL cycle 0,1,...,7,0 with no index skipped.

Reset
REQ-026 rst_=0 SHALL immediately force IDLE, a=b=c=0, g1=0, g2a_=1, g2b_=1, busy=0, tmo=0, counters=0, last=7 (first grant favours index 0).
REQ-027 Reset asserted mid-ACTIVE SHALL drop g2a_ and g2b_ high asynchronously without waiting for a clock edge.
REQ-028 After rst_ release, g1 SHALL go high on the first clock edge and arbitration SHALL start on the following edge.

Verification
REQ-029 Single request: req_=8'hFB (idx 2), wlen=0, done_=0 -> {c,b,a}=3'b010, g2b_ low 3 cycles, g2a_ low 1 cycle, busy high 3 cycles.
REQ-030 All requesting, wlen=1, done_=0 -> grant order 0..7 then 0; each g2a_ pulse 2 cycles; strobes separated by 3 cycles.
REQ-031 Timeout: TMAX=8, done_=1 held -> g2a_ low 8 cycles, tmo=1 for 1 cycle entering RECOVER, next requester granted.
REQ-032 done_ low on same edge as timeout expiry -> normal exit, tmo stays 0.
REQ-033 rst_ pulled low during ACTIVE of idx 5 -> g2a_=g2b_=1, g1=0, abc=0 immediately; after release first grant goes to lowest requesting index from 0.
REQ-034 en=0 with req_=8'h00 -> busy stays 0 indefinitely; en=1 -> grant starts next edge.
